// File: rtl/led_line_fetcher.sv
// led_line_fetcher: fetches one display line of pixel words through a memory_arbiter read slot
// and streams them to the LED shift stage via a credit-limited show-ahead buffer.
// Latency: first req_mem 2 cycles after start; buffered words visible 1 cycle after return.
// Backpressure: requests stall on fifo_full_mem or zero credit; pix_ready stalls the buffer.
// Optional build macro LED_LINE_FETCHER_ERR_EN adds a sticky err output for stray read returns.
module led_line_fetcher #(
  parameter int ADDRESS_WIDTH = 14,
  parameter int DATA_WIDTH    = 16,
  parameter int BUF_DEPTH     = 8,
  parameter int FB1_BASE      = 8192
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     frame_buffer_select,
  input  logic [4:0]               line,
  input  logic [9:0]               pixels_per_row,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] address_mem,
  output logic                     wr_mem,
  output logic                     req_mem,
  input  logic                     fifo_full_mem,
  input  logic [DATA_WIDTH-1:0]    data_in_mem,
  input  logic                     data_in_ready_mem,
  output logic [DATA_WIDTH-1:0]    pix_data,
  output logic                     pix_valid,
  input  logic                     pix_ready
`ifdef LED_LINE_FETCHER_ERR_EN
  ,
  output logic                     err
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_FETCH,
    S_DONE
  } state_t;

  state_t                   state_q;
  logic                     fb_q;
  logic [4:0]               line_q;
  logic [9:0]               ppr_q;
  logic [ADDRESS_WIDTH-1:0] base_q;
  logic [9:0]               req_idx_q;
  logic [9:0]               rx_cnt_q;
  logic [9:0]               tx_cnt_q;
  logic [CW-1:0]            credit_q;
  logic [PW:0]              wr_ptr_q;
  logic [PW:0]              rd_ptr_q;
  logic [DATA_WIDTH-1:0]    mem_q [BUF_DEPTH];
  logic                     busy_q;
  logic                     done_q;

  logic [14:0]              line_prod;
  logic [ADDRESS_WIDTH-1:0] base_d;
  logic                     is_fetch;
  logic                     issue;
  logic                     buf_empty;
  logic                     buf_full;
  logic                     pix_hs;
  logic                     buf_wr;
  logic [CW-1:0]            credit_d;
  logic [9:0]               tx_cnt_d;

  // Line offset is formed at 15 bits so 31*1023 cannot overflow before address truncation.
  assign line_prod = 15'(line_q) * 15'(ppr_q);
  assign base_d    = (fb_q ? ADDRESS_WIDTH'(FB1_BASE) : '0) + ADDRESS_WIDTH'(line_prod);

  assign is_fetch  = (state_q == S_FETCH);
  assign buf_empty = (wr_ptr_q == rd_ptr_q);
  assign buf_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign pix_hs    = !buf_empty && pix_ready;

  // A request goes out only with a free buffer slot reserved for its return.
  assign issue = is_fetch && (req_idx_q < ppr_q) && !fifo_full_mem && (credit_q != '0);

`ifdef LED_LINE_FETCHER_ERR_EN
  logic [9:0] outstanding;
  logic       stray;
  logic       err_q;
  assign outstanding = req_idx_q - rx_cnt_q;
  assign stray       = data_in_ready_mem && ((state_q == S_IDLE) || (outstanding == '0));
  assign buf_wr      = data_in_ready_mem && is_fetch && !stray && (!buf_full || pix_hs);
  assign err         = err_q;
`else
  assign buf_wr      = data_in_ready_mem && is_fetch && (!buf_full || pix_hs);
`endif

  // Credit and transmit-count next state; a simultaneous issue and accept cancel out.
  always_comb begin
    credit_d = credit_q;
    if (issue && !pix_hs) begin
      credit_d = credit_q - 1'b1;
    end else if (!issue && pix_hs) begin
      credit_d = credit_q + 1'b1;
    end
    tx_cnt_d = tx_cnt_q + {9'd0, pix_hs};
  end

  // Main FSM: latch the line request, set up the base, stream the fetch and pulse done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      fb_q      <= 1'b0;
      line_q    <= '0;
      ppr_q     <= '0;
      base_q    <= '0;
      req_idx_q <= '0;
      rx_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      credit_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            fb_q    <= frame_buffer_select;
            line_q  <= line;
            ppr_q   <= pixels_per_row;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_SETUP: begin
          base_q    <= base_d;
          req_idx_q <= '0;
          rx_cnt_q  <= '0;
          tx_cnt_q  <= '0;
          credit_q  <= CW'(BUF_DEPTH);
          wr_ptr_q  <= '0;
          rd_ptr_q  <= '0;
          if (ppr_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (issue) begin
            req_idx_q <= req_idx_q + 1'b1;
          end
          if (buf_wr) begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
            wr_ptr_q <= wr_ptr_q + 1'b1;
          end
          if (pix_hs) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
          end
          credit_q <= credit_d;
          tx_cnt_q <= tx_cnt_d;
          if (tx_cnt_d == ppr_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LED_LINE_FETCHER_ERR_EN
  // Sticky flag for read data that no outstanding request accounts for.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (stray) begin
      err_q <= 1'b1;
    end
  end
`endif

  // Buffer storage; emptiness is tracked by the pointers so contents need no reset.
  always_ff @(posedge clk) begin
    if (buf_wr) begin
      mem_q[wr_ptr_q[PW-1:0]] <= data_in_mem;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign wr_mem      = 1'b0;
  assign req_mem     = issue;
  assign address_mem = issue ? (base_q + ADDRESS_WIDTH'(req_idx_q)) : '0;
  assign pix_valid   = !buf_empty;
  assign pix_data    = buf_empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: tb/tb_led_line_fetcher.sv
// Bench for led_line_fetcher: arbiter model returns the request address as data after 2 cycles;
// expected addresses/pixels are queued at each start and popped by an independent monitor.
module tb_led_line_fetcher;

  localparam int AW = 14;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          fb_sel;
  logic [4:0]    line_idx;
  logic [9:0]    ppr;
  logic          busy;
  logic          done;
  logic [AW-1:0] address_mem;
  logic          wr_mem;
  logic          req_mem;
  logic          fifo_full_mem;
  logic [DW-1:0] data_in_mem;
  logic          data_in_ready_mem;
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
`ifdef LED_LINE_FETCHER_ERR_EN
  logic          err;
`endif

  led_line_fetcher #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BUF_DEPTH(8),
    .FB1_BASE(8192)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .frame_buffer_select(fb_sel),
    .line(line_idx),
    .pixels_per_row(ppr),
    .busy(busy),
    .done(done),
    .address_mem(address_mem),
    .wr_mem(wr_mem),
    .req_mem(req_mem),
    .fifo_full_mem(fifo_full_mem),
    .data_in_mem(data_in_mem),
    .data_in_ready_mem(data_in_ready_mem),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready)
`ifdef LED_LINE_FETCHER_ERR_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_addr_q[$];
  int exp_pix_q[$];
  int due_q[$];
  int dat_q[$];

  int req_cnt, pix_cnt, done_cnt, blocked_viol, busy_at_done;
  int first_req_cyc, first_req_addr, last_acc_cyc, done_cyc, start_cyc;
  logic inject_stray = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_stats();
    req_cnt = 0; pix_cnt = 0; done_cnt = 0; blocked_viol = 0; busy_at_done = 0;
    first_req_cyc = -1; first_req_addr = -1; last_acc_cyc = -1; done_cyc = -1;
  endtask

  // Issue a start pulse and queue the expected address/pixel stream for it.
  task automatic do_start(input int fbv, input int linev, input int pprv);
    int base;
    clear_stats();
    base = ((fbv != 0 ? 8192 : 0) + linev * pprv) % 16384;
    for (int i = 0; i < pprv; i++) begin
      exp_addr_q.push_back((base + i) % 16384);
      exp_pix_q.push_back((base + i) % 16384);
    end
    fb_sel = fbv[0]; line_idx = linev[4:0]; ppr = pprv[9:0];
    start = 1'b1;
    start_cyc = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int b = 0;
    while (done_cnt == 0 && b < budget) begin
      tick(1);
      b++;
    end
    if (done_cnt == 0) fail_now({name, "_done_timeout"});
    tick(2);
  endtask

  // Arbiter model: every request returns its own address as data two cycles later.
  initial begin
    data_in_ready_mem = 1'b0;
    data_in_mem = '0;
    forever begin
      @(negedge clk);
      if (req_mem) begin
        due_q.push_back(cyc + 2);
        dat_q.push_back(int'(address_mem));
      end
      @(posedge clk);
      #2;
      if (inject_stray) begin
        data_in_ready_mem = 1'b1;
        data_in_mem = 16'hDEAD;
      end else if (due_q.size() > 0 && due_q[0] == cyc) begin
        data_in_ready_mem = 1'b1;
        data_in_mem = 16'(dat_q.pop_front());
        void'(due_q.pop_front());
      end else begin
        data_in_ready_mem = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every request and every pixel handshake.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (req_mem) begin
          if (req_cnt == 0) begin
            first_req_cyc = cyc;
            first_req_addr = int'(address_mem);
          end
          req_cnt++;
          if (fifo_full_mem) blocked_viol++;
          if (exp_addr_q.size() == 0) fail_now("unexpected_req");
          else begin
            e = exp_addr_q.pop_front();
            check("req_addr", int'(address_mem), e);
          end
        end
        if (pix_valid && pix_ready) begin
          pix_cnt++;
          last_acc_cyc = cyc;
          if (exp_pix_q.size() == 0) fail_now("unexpected_pix");
          else begin
            e = exp_pix_q.pop_front();
            check("pix_data", int'(pix_data), e);
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          if (busy) busy_at_done++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; fb_sel = 1'b0; line_idx = '0; ppr = '0;
    fifo_full_mem = 1'b0; pix_ready = 1'b0;
    clear_stats();
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", req_mem, 0);
    check("rst_addr", int'(address_mem), 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_wr_mem", wr_mem, 0);
`ifdef LED_LINE_FETCHER_ERR_EN
    check("rst_err", err, 0);
`endif
    reset_n = 1'b1;
    tick(2);

    // Short line from frame buffer 0.
    pix_ready = 1'b1;
    do_start(0, 3, 4);
    check("t1_busy_after_start", busy, 1);
    wait_done(60, "t1");
    check("t1_first_req_latency", first_req_cyc - start_cyc, 2);
    check("t1_first_addr", first_req_addr, 12);
    check("t1_words", pix_cnt, 4);
    check("t1_done_count", done_cnt, 1);
    check("t1_done_after_last_accept", done_cyc - last_acc_cyc, 1);
    check("t1_busy_in_done_cycle", busy_at_done, 0);
    check("t1_busy_after", busy, 0);

    // Frame buffer 1, last line, 512 words; base truncates to 14 bits.
    do_start(1, 31, 512);
    wait_done(2000, "t2");
    check("t2_first_addr", first_req_addr, 7680);
    check("t2_words", pix_cnt, 512);
    check("t2_done_count", done_cnt, 1);

    // Downstream stalled: only BUF_DEPTH requests may be outstanding/buffered.
    pix_ready = 1'b0;
    do_start(0, 5, 20);
    tick(40);
    check("t3_req_while_stalled", req_cnt, 8);
    check("t3_pix_valid_stalled", pix_valid, 1);
    pix_ready = 1'b1;
    wait_done(300, "t3");
    check("t3_req_total", req_cnt, 20);
    check("t3_words", pix_cnt, 20);
    check("t3_done_count", done_cnt, 1);

    // Arbiter slot full during cycles 3..10 after start.
    do_start(0, 2, 16);
    tick(2);
    fifo_full_mem = 1'b1;
    tick(8);
    fifo_full_mem = 1'b0;
    check("t4_req_before_release", req_cnt, 1);
    wait_done(300, "t4");
    check("t4_req_while_full", blocked_viol, 0);
    check("t4_words", pix_cnt, 16);
    check("t4_req_total", req_cnt, 16);

    // Empty line.
    do_start(0, 7, 0);
    wait_done(20, "t5a");
    check("t5_done_latency", done_cyc - start_cyc, 2);
    check("t5_no_req", req_cnt, 0);
    check("t5_no_pix", pix_cnt, 0);

    // Second start while busy is ignored.
    do_start(0, 1, 6);
    tick(2);
    fb_sel = 1'b1; line_idx = 5'd9; ppr = 10'd3; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(100, "t5b");
    tick(10);
    check("t5_first_addr", first_req_addr, 6);
    check("t5_words", pix_cnt, 6);
    check("t5_single_done", done_cnt, 1);

    // Address wrap inside a line: 16159..16383 then 0..31.
    do_start(1, 31, 257);
    wait_done(800, "t7");
    check("t7_first_addr", first_req_addr, 16159);
    check("t7_words", pix_cnt, 257);

    // Reset in the middle of a fetch.
    do_start(0, 4, 20);
    tick(4);
    reset_n = 1'b0;
    exp_addr_q.delete();
    exp_pix_q.delete();
    tick(1);
    reset_n = 1'b1;
    check("t6_busy_after_rst", busy, 0);
    check("t6_done_after_rst", done, 0);
    check("t6_req_after_rst", req_mem, 0);
    check("t6_addr_after_rst", int'(address_mem), 0);
    check("t6_pix_valid_after_rst", pix_valid, 0);
    check("t6_pix_data_after_rst", int'(pix_data), 0);
    clear_stats();
    tick(20);
    check("t6_no_done", done_cnt, 0);
    check("t6_late_data_dropped", pix_cnt, 0);
    do_start(0, 0, 3);
    wait_done(60, "t6_recover");
    check("t6_recover_first_addr", first_req_addr, 0);
    check("t6_recover_words", pix_cnt, 3);

`ifdef LED_LINE_FETCHER_ERR_EN
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check("err_clear", err, 0);
    inject_stray = 1'b1;
    tick(1);
    inject_stray = 1'b0;
    tick(1);
    check("err_set", err, 1);
    tick(5);
    check("err_sticky", err, 1);
    check("err_stray_not_buffered", pix_valid, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_line_fetcher.md
Name: led_line_fetcher

Overview:
Read-side client of memory_arbiter. It fetches one display line of pixel words from the active frame buffer and streams them to the LED shift stage through a small credit-limited buffer. One instance per panel row occupies one arbiter peripheral slot, alongside the device_controller slot. It replaces ad-hoc read issuing inside the LED path with a fixed request/return protocol.

Parameters:
ADDRESS_WIDTH, 14, arbiter word-address width
DATA_WIDTH, 16, pixel word width
BUF_DEPTH, 8, return buffer entries; power of 2, at least 2
FB1_BASE, 8192, word address of frame buffer 1; frame buffer 0 base is 0

Ports:
clk  in  1  system clock (clk_sys domain)
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse: begin fetching a line
frame_buffer_select  in  1  0 = frame buffer 0, 1 = frame buffer 1; sampled on start
line  in  5  line index; sampled on start
pixels_per_row  in  10  words per line, 0..1023; sampled on start
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse: last word accepted downstream
address_mem  out  ADDRESS_WIDTH  read address to arbiter
wr_mem  out  1  tied 0 (read-only client)
req_mem  out  1  request strobe to arbiter data_in_ready slot
fifo_full_mem  in  1  arbiter slot FIFO full; no request is issued while high
data_in_mem  in  DATA_WIDTH  arbiter read data
data_in_ready_mem  in  1  read data valid for this slot
pix_data  out  DATA_WIDTH  buffered pixel word
pix_valid  out  1  pix_data valid
pix_ready  in  1  downstream accept

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on reset_n. While reset_n is low at a clk edge, every output is 0, the FSM goes to IDLE, and the buffer and all counters clear. Reset during a fetch abandons it with no done pulse. Responses arriving after reset are discarded until the next start.
- FSM IDLE -> SETUP: on start. Latch the inputs and assert busy next cycle. A start while busy is ignored.
- SETUP, one cycle: base = (frame_buffer_select ? FB1_BASE : 0) + line*pixels_per_row, truncated to ADDRESS_WIDTH. Clear req_idx, rx_cnt and tx_cnt. Go to DONE if pixels_per_row == 0, else to FETCH.
- FETCH, request issue: req_mem=1 with address_mem = base + req_idx (mod 2^ADDRESS_WIDTH) when all of these hold:
  - req_idx < pixels_per_row
  - fifo_full_mem == 0
  - credit > 0
  req_idx increments on each issued request.
- Credit: starts at BUF_DEPTH. It decrements per issued request and increments per pix handshake (pix_valid & pix_ready). If both occur in the same cycle, credit is unchanged. Outstanding requests plus buffered words never exceed BUF_DEPTH, so the buffer cannot overflow.
- Return: each data_in_ready_mem cycle writes data_in_mem into the buffer and increments rx_cnt. Returns are in order (arbiter guarantee).
- Output: pix_valid = buffer not empty; pix_data = buffer head. Show-ahead: a word written in cycle N is visible on pix_data in cycle N+1. Simultaneous write and read on an empty or full buffer is handled.
- FETCH -> DONE: when tx_cnt reaches pixels_per_row.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then IDLE.
- Latency: the first req_mem is 2 cycles after start, given fifo_full_mem=0.
- Address wrap: a sum overflowing ADDRESS_WIDTH wraps silently.
- Width rule: line*pixels_per_row is computed at 15 bits before truncation.

Optional Feature:
Macro LED_LINE_FETCHER_ERR_EN.
- Defined: adds output err (1 bit, sticky), which sets if either:
  - data_in_ready_mem is high while outstanding (issued minus received) == 0
  - data_in_ready_mem is high while in IDLE
  err clears only on reset. Stray data is dropped, not buffered.
- Undefined: no err port. Stray data is written if in FETCH and ignored otherwise.

Test Plan:
1. fb=0, line=3, pixels_per_row=4, pix_ready=1, arbiter returns addr as data with 2-cycle latency -> addresses 12,13,14,15; pix_data 12,13,14,15 in order; done 1 cycle after the last accept; busy low in the done cycle.
2. fb=1, line=31, ppr=512 -> first address (8192+15872) mod 16384 = 7680; 512 words delivered; done pulse once.
3. ppr=20, pix_ready=0 throughout -> exactly BUF_DEPTH=8 requests issued, pix_valid high, no further req_mem. Releasing pix_ready -> remaining 12 requests complete; 20 words total.
4. fifo_full_mem held high for cycles 3-10 of a fetch -> req_mem=0 on those cycles; issuing resumes with no skipped or duplicate address.
5. ppr=0 -> no req_mem; done 2 cycles after start. A start during busy on a normal fetch -> ignored, one done only.
6. reset_n low mid-fetch for 1 cycle -> all outputs 0 next cycle, no done. With LED_LINE_FETCHER_ERR_EN, a data_in_ready_mem pulse in IDLE -> err=1 and stays high.
